// File: rtl/axi_slv_rd_ctrl_pkg.sv
// Shared AXI definitions for the read-slave controller: bus widths,
// burst/response encodings and the controller's FSM states.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

package axi_slv_rd_ctrl_pkg;
  localparam int ID_W     = `AXI_ID_WIDTH;
  localparam int ADDR_W   = `AXI_ADDR_WIDTH;
  localparam int LEN_W    = `AXI_LEN_WIDTH;
  localparam int SIZE_W   = `AXI_SIZE_WIDTH;
  localparam int BURST_W  = `AXI_BURST_WIDTH;
  localparam int DATA_W   = `AXI_DATA_WIDTH;
  localparam int RESP_W   = `AXI_RESP_WIDTH;
  localparam int LOCK_W   = `AXI_LOCK_WIDTH;
  localparam int CACHE_W  = `AXI_CACHE_WIDTH;
  localparam int PROT_W   = `AXI_PROT_WIDTH;
  localparam int QOS_W    = `AXI_QOS_WIDTH;
  localparam int REGION_W = `AXI_REGION_WIDTH;

  // Largest legal arsize: a beat may not be wider than the data bus.
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_RESP
  } state_e;
endpackage

// File: rtl/axi_slv_rd_ctrl_addr_gen.sv
// Combinational AXI next-beat address generator for FIXED, INCR and WRAP
// bursts; the reserved encoding leaves the address unchanged.
module axi_burst_addr_gen
  import axi_slv_rd_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  input  logic [SIZE_W-1:0]  size,
  input  logic [LEN_W-1:0]   len,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr
);
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;

  // WRAP keeps the bits above the wrap window and wraps the offset inside it.
  always_comb begin
    step      = ADDR_W'(1) << size;
    incr      = addr + step;
    mask      = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    next_addr = addr;
    case (burst_e'(burst))
      BURST_INCR: next_addr = incr;
      BURST_WRAP: next_addr = (addr & ~mask) | (incr & mask);
      default:    next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi_slv_rd_ctrl.sv
// AXI read slave: accepts one burst at a time, reads each beat from a
// one-cycle-latency memory and returns it on R, flagging bad beats with SLVERR.
module axi_slv_rd_ctrl
  import axi_slv_rd_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                axi_slv_arvalid,
  output logic                axi_slv_arready,
  input  logic [ID_W-1:0]     axi_slv_arid,
  input  logic [ADDR_W-1:0]   axi_slv_araddr,
  input  logic [LEN_W-1:0]    axi_slv_arlen,
  input  logic [SIZE_W-1:0]   axi_slv_arsize,
  input  logic [BURST_W-1:0]  axi_slv_arburst,
  input  logic [LOCK_W-1:0]   axi_slv_arlock,
  input  logic [CACHE_W-1:0]  axi_slv_arcache,
  input  logic [PROT_W-1:0]   axi_slv_arprot,
  input  logic [QOS_W-1:0]    axi_slv_arqos,
  input  logic [REGION_W-1:0] axi_slv_arregion,
  output logic                axi_slv_rvalid,
  input  logic                axi_slv_rready,
  output logic [ID_W-1:0]     axi_slv_rid,
  output logic [DATA_W-1:0]   axi_slv_rdata,
  output logic [RESP_W-1:0]   axi_slv_rresp,
  output logic                axi_slv_rlast,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_rd_data
);
  state_e             state, next_state;
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  addr_q, next_addr;
  logic [LEN_W-1:0]   len_q;
  logic [SIZE_W-1:0]  size_q;
  logic [BURST_W-1:0] burst_q;
  logic [LEN_W:0]     beat_cnt;
  logic [DATA_W-1:0]  rdata_q;
  logic               resp_first;
  logic               beat_err;
  logic               last_beat;

  wire unused_sideband = &{1'b0, axi_slv_arlock, axi_slv_arcache, axi_slv_arprot,
                           axi_slv_arqos, axi_slv_arregion};

  assign beat_err  = (addr_q >= ADDR_LIMIT) || (burst_q == BURST_RSVD) ||
                     (size_q > SIZE_W'(MAX_SIZE));
  assign last_beat = (beat_cnt == {1'b0, len_q});
  assign mem_rd_addr = addr_q;
  assign axi_slv_rid = id_q;

  axi_burst_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Memory data is only present in the first RESP cycle, so it is passed
  // straight through then and replayed from rdata_q while R is stalled.
  always_comb begin
    next_state      = state;
    axi_slv_arready = (state == ST_IDLE);
    axi_slv_rvalid  = (state == ST_RESP);
    mem_rd_en       = (state == ST_MEM) && !beat_err;
    axi_slv_rlast   = axi_slv_rvalid && last_beat;
    axi_slv_rresp   = (axi_slv_rvalid && beat_err) ? RESP_SLVERR : RESP_OKAY;
    axi_slv_rdata   = rdata_q;
    if (resp_first) axi_slv_rdata = beat_err ? '0 : mem_rd_data;
    case (state)
      ST_IDLE: if (axi_slv_arvalid) next_state = ST_MEM;
      ST_MEM:  next_state = ST_RESP;
      ST_RESP: if (axi_slv_rready) next_state = last_beat ? ST_IDLE : ST_MEM;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt   <= '0;
      rdata_q    <= '0;
      resp_first <= 1'b0;
    end else begin
      resp_first <= (state == ST_MEM);
      if (resp_first) rdata_q <= axi_slv_rdata;
      if (state == ST_IDLE && axi_slv_arvalid) begin
        id_q     <= axi_slv_arid;
        addr_q   <= axi_slv_araddr;
        len_q    <= axi_slv_arlen;
        size_q   <= axi_slv_arsize;
        burst_q  <= axi_slv_arburst;
        beat_cnt <= '0;
      end else if (state == ST_RESP && axi_slv_rready && !last_beat) begin
        addr_q   <= next_addr;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule
